// File: rtl/serdes_pkg.sv
// Shared definitions for the 5-bit serial link.
// Contents:
//   FRAME_W      - bits per frame (5)
//   CNT_W        - width of the per-frame bit counter (counts 0..5)
//   ERR_CNT_W    - width of the framing-error counter (8)
//   deser_state_e- receiver states IDLE / RECV / DRAIN
//   sat_inc_err  - saturating increment for the framing-error counter
package serdes_pkg;

    localparam int FRAME_W   = 5;
    localparam int CNT_W     = 3;
    localparam int ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2
    } deser_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] v);
        logic [ERR_CNT_W-1:0] r;
        if (v == {ERR_CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + ERR_CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/deserializer_5bit_if.sv
// Bus bundle between the 5-bit serializer side and the deserializer.
// Signals:
//   serial_i  - serial data, MSB first, one bit per clk
//   busy_i    - frame envelope, high for the bit cycles of a frame
//   data_o    - last correctly received frame
//   valid_o   - one-cycle pulse when data_o updates
//   err_o     - one-cycle pulse on a short or long frame
//   rx_busy_o - receiver is assembling a frame
//   err_cnt_o - saturating framing-error count
// Modports: master drives the serial side, slave is the deserializer.
interface deserializer_5bit_if;
    import serdes_pkg::*;

    logic                 serial_i;
    logic                 busy_i;
    logic [FRAME_W-1:0]   data_o;
    logic                 valid_o;
    logic                 err_o;
    logic                 rx_busy_o;
    logic [ERR_CNT_W-1:0] err_cnt_o;

    modport master (
        output serial_i, busy_i,
        input  data_o, valid_o, err_o, rx_busy_o, err_cnt_o
    );

    modport slave (
        input  serial_i, busy_i,
        output data_o, valid_o, err_o, rx_busy_o, err_cnt_o
    );

endinterface

// File: rtl/deser_shift_5bit.sv
// Shift register and bit counter for the 5-bit deserializer.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   shift_en     - shift serial_in in at bit 0 and count it
//   clear        - drop the partial word; with shift_en, start a new word
//   serial_in    - incoming bit
//   word_out     - current shift register contents
//   count_out    - bits collected so far, saturates at FRAME_W
module deser_shift_5bit
    import serdes_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               shift_en,
    input  logic               clear,
    input  logic               serial_in,
    output logic [FRAME_W-1:0] word_out,
    output logic [CNT_W-1:0]   count_out
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

    logic [FRAME_W-1:0] shift_r;
    logic [CNT_W-1:0]   count_r;

    // Shift register / counter; clear+shift_en loads the first bit of a frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_r <= {FRAME_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (clear && shift_en) begin
            shift_r <= {{(FRAME_W-1){1'b0}}, serial_in};
            count_r <= CNT_W'(1);
        end else if (clear) begin
            shift_r <= {FRAME_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (shift_en) begin
            shift_r <= {shift_r[FRAME_W-2:0], serial_in};
            if (count_r != CNT_FULL) begin
                count_r <= count_r + CNT_W'(1);
            end else begin
                count_r <= count_r;
            end
        end else begin
            shift_r <= shift_r;
            count_r <= count_r;
        end
    end

    assign word_out  = shift_r;
    assign count_out = count_r;

endmodule

// File: rtl/deserializer_5bit.sv
// 5-bit deserializer: reassembles MSB-first frames framed by busy_i.
// A frame of exactly FRAME_W bits produces data_o/valid_o one clk after
// its last bit; shorter frames and frames that run past FRAME_W bits
// produce a single err_o pulse. Over-long frames are drained until busy_i
// falls.
// Ports:
//   clk    - clock, rising edge
//   reset  - asynchronous active-low reset
//   bus    - deserializer_5bit_if.slave (serial_i, busy_i in; data_o,
//            valid_o, err_o, rx_busy_o, err_cnt_o out)
// Configuration:
//   DESER_5BIT_ERR_CNT_EN - when defined, err_cnt_o counts err_o pulses
//                           (saturating at 255); otherwise it is tied to 0.
module deserializer_5bit
    import serdes_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    deserializer_5bit_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

    deser_state_e       state_r, state_s;
    logic               shift_en_s, clear_s;
    logic [FRAME_W-1:0] word_s;
    logic [CNT_W-1:0]   count_s;
    logic [FRAME_W-1:0] data_r, data_s;
    logic               valid_r, valid_s;
    logic               err_r, err_s;
    logic               rx_busy_r;

    deser_shift_5bit u_shift (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (shift_en_s),
        .clear     (clear_s),
        .serial_in (bus.serial_i),
        .word_out  (word_s),
        .count_out (count_s)
    );

    // Next-state, shifter control and pulse decode.
    always_comb begin
        state_s    = state_r;
        shift_en_s = 1'b0;
        clear_s    = 1'b0;
        data_s     = data_r;
        valid_s    = 1'b0;
        err_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.busy_i) begin
                    shift_en_s = 1'b1;
                    clear_s    = 1'b1;
                    state_s    = RECV;
                end else begin
                    state_s    = IDLE;
                end
            end
            RECV: begin
                if (bus.busy_i) begin
                    if (count_s == CNT_FULL) begin
                        // Bit beyond the frame: long frame.
                        err_s   = 1'b1;
                        clear_s = 1'b1;
                        state_s = DRAIN;
                    end else begin
                        shift_en_s = 1'b1;
                        if (count_s == CNT_LAST) begin
                            // Last bit: publish the word in the same edge it
                            // is sampled. The truncating cast drops the
                            // oldest shift bit, which falls off the frame.
                            data_s  = FRAME_W'({word_s, bus.serial_i});
                            valid_s = 1'b1;
                        end else begin
                            valid_s = 1'b0;
                        end
                    end
                end else begin
                    // Envelope closed; anything short of a full frame is an error.
                    if (count_s != CNT_FULL) begin
                        err_s = 1'b1;
                    end else begin
                        err_s = 1'b0;
                    end
                    clear_s = 1'b1;
                    state_s = IDLE;
                end
            end
            DRAIN: begin
                if (bus.busy_i) begin
                    state_s = DRAIN;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                clear_s = 1'b1;
                state_s = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            data_r    <= {FRAME_W{1'b0}};
            valid_r   <= 1'b0;
            err_r     <= 1'b0;
            rx_busy_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            data_r    <= data_s;
            valid_r   <= valid_s;
            err_r     <= err_s;
            rx_busy_r <= (state_s == RECV);
        end
    end

`ifdef DESER_5BIT_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_r;

    // Framing-error counter, advances with every err_o pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt_r <= {ERR_CNT_W{1'b0}};
        end else if (err_s) begin
            err_cnt_r <= sat_inc_err(err_cnt_r);
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign bus.err_cnt_o = err_cnt_r;
`else
    assign bus.err_cnt_o = {ERR_CNT_W{1'b0}};
`endif

    assign bus.data_o    = data_r;
    assign bus.valid_o   = valid_r;
    assign bus.err_o     = err_r;
    assign bus.rx_busy_o = rx_busy_r;

endmodule

// File: tb/tb_deserializer_5bit.sv
// Self-checking bench for deserializer_5bit: expected valid/err pulses are
// queued when a frame is driven and matched against DUT pulses.
module tb_deserializer_5bit;
    import serdes_pkg::*;

    typedef struct packed {
        logic       is_err;
        logic [4:0] data;
    } exp_t;

    logic clk;
    logic reset;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_vec;
    int         n_miss;
    int         exp_err_raw;
    logic [4:0] last_data;
    logic [4:0] rnd_w;

    deserializer_5bit_if bus_if ();

    deserializer_5bit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef DESER_5BIT_ERR_CNT_EN
        return (exp_err_raw > 255) ? 32'd255 : 32'(exp_err_raw);
`else
        return 32'd0;
`endif
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive nbits cycles of busy; the first five carry w MSB first.
    task automatic send_frame(input logic [4:0] w, input int nbits);
        exp_t e;
        if (nbits >= 5) begin
            e.is_err = 1'b0;
            e.data   = w;
            exp_q.push_back(e);
            last_data = w;
        end
        if (nbits != 5) begin
            e.is_err = 1'b1;
            e.data   = 5'd0;
            exp_q.push_back(e);
            exp_err_raw++;
        end
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) check_eq("rx_busy_mid", 32'(bus_if.rx_busy_o), 32'd1);
            if (i >= 6) check_eq("drain_state", 32'(dut.state_r), 32'(DRAIN));
            bus_if.busy_i   = 1'b1;
            bus_if.serial_i = (i < 5) ? w[4-i] : 1'($urandom);
        end
        @(posedge clk);
        #1;
        bus_if.busy_i   = 1'b0;
        bus_if.serial_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_data"},    32'(bus_if.data_o),    32'd0);
        check_eq({tag, "_valid"},   32'(bus_if.valid_o),   32'd0);
        check_eq({tag, "_err"},     32'(bus_if.err_o),     32'd0);
        check_eq({tag, "_rx_busy"}, 32'(bus_if.rx_busy_o), 32'd0);
        check_eq({tag, "_err_cnt"}, 32'(bus_if.err_cnt_o), 32'd0);
    endtask

    // Pulse monitor: every valid/err pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (bus_if.valid_o || bus_if.err_o) begin
            check_eq("valid_err_exclusive", 32'(bus_if.valid_o & bus_if.err_o), 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse", {30'd0, bus_if.valid_o, bus_if.err_o}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("pulse_kind", {30'd0, bus_if.valid_o, bus_if.err_o},
                         mon_e.is_err ? 32'd1 : 32'd2);
                if (bus_if.valid_o) check_eq("data_o", 32'(bus_if.data_o), 32'(mon_e.data));
            end
        end
    end

    initial begin
        n_vec           = 0;
        n_miss          = 0;
        exp_err_raw     = 0;
        last_data       = 5'd0;
        reset           = 1'b0;
        bus_if.busy_i   = 1'b0;
        bus_if.serial_i = 1'b0;

        idle(2);
        check_all_zero("reset");
        reset = 1'b1;
        idle(2);

        // Single frame 10110.
        send_frame(5'b10110, 5);
        idle(2);
        check_eq("single_hold", 32'(bus_if.data_o), 32'(last_data));
        check_eq("single_err_cnt", 32'(bus_if.err_cnt_o), exp_cnt());

        // Back-to-back frames with a one-cycle gap.
        send_frame(5'h1F, 5);
        send_frame(5'h00, 5);
        send_frame(5'h15, 5);
        idle(3);
        check_eq("b2b_last", 32'(bus_if.data_o), 32'h15);

        // Short frame: data_o must keep 0x15.
        send_frame(5'b11100, 3);
        idle(3);
        check_eq("short_hold", 32'(bus_if.data_o), 32'h15);
        check_eq("short_err_cnt", 32'(bus_if.err_cnt_o), exp_cnt());

        // Long frame: valid for 01011, one err, drain until busy falls.
        send_frame(5'b01011, 8);
        idle(2);
        check_eq("long_data", 32'(bus_if.data_o), 32'h0B);
        check_eq("long_back_idle", 32'(dut.state_r), 32'(IDLE));
        check_eq("long_err_cnt", 32'(bus_if.err_cnt_o), exp_cnt());

        // Reset after two bits of a frame.
        @(posedge clk); #1;
        bus_if.busy_i = 1'b1; bus_if.serial_i = 1'b1;
        @(posedge clk); #1;
        bus_if.serial_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        bus_if.busy_i = 1'b0;
        #1;
        check_all_zero("midframe_reset");
        last_data   = 5'd0;
        exp_err_raw = 0;
        idle(2);
        reset = 1'b1;
        idle(1);
        send_frame(5'h0A, 5);
        idle(2);
        check_eq("after_reset_data", 32'(bus_if.data_o), 32'h0A);

        // Random full frames with varying gaps.
        for (int k = 0; k < 6; k++) begin
            rnd_w = 5'($urandom);
            send_frame(rnd_w, 5);
            idle($urandom_range(0, 2));
        end
        idle(2);
        check_eq("random_hold", 32'(bus_if.data_o), 32'(last_data));

        // 260 short frames to exercise counter saturation.
        for (int k = 0; k < 260; k++) begin
            rnd_w = 5'($urandom);
            send_frame(rnd_w, $urandom_range(1, 4));
        end
        idle(3);
        check_eq("sat_err_cnt", 32'(bus_if.err_cnt_o), exp_cnt());
        check_eq("sat_data_hold", 32'(bus_if.data_o), 32'(last_data));

        // A good frame still works after saturation.
        send_frame(5'h13, 5);
        idle(3);
        check_eq("post_sat_data", 32'(bus_if.data_o), 32'h13);
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
